// File: rtl/forward_ctrl.sv
// ============================================================================
// forward_ctrl : EX-stage operand forwarding selects and load-use stall detect
// Rev 1.0
// ============================================================================
`default_nettype none

module forward_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    input  logic             mem_stall_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o
);

    localparam logic [1:0] c_sel_rf  = 2'b00;
    localparam logic [1:0] c_sel_wb  = 2'b01;
    localparam logic [1:0] c_sel_mem = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } ex_rec_t;

    // Past EX only the producer side of a record is ever consulted.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } late_rec_t;

    localparam ex_rec_t   c_ex_bubble   = '0;
    localparam late_rec_t c_late_bubble = '0;

    ex_rec_t   ex_q,  ex_d;
    late_rec_t mem_q, mem_d;
    late_rec_t wb_q,  wb_d;

    logic w_ex_load_hit;

    function automatic logic writes_reg(input late_rec_t r, input logic [REG_W-1:0] rs);
        return r.valid && r.regwrite && (r.rd != '0) && (r.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs, input ex_rec_t ex,
                                           input late_rec_t m, input late_rec_t w);
        logic [1:0] sel;
        sel = c_sel_rf;
        if (ex.valid) begin
            if (writes_reg(m, rs)) begin
                sel = c_sel_mem;
            end else if (writes_reg(w, rs)) begin
                sel = c_sel_wb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_ex_load_hit = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                        ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
        stall_o = id_valid_i && w_ex_load_hit && !flush_i && !mem_stall_i;
        fwd_a_o = fwd_sel(ex_q.rs1, ex_q, mem_q, wb_q);
        fwd_b_o = fwd_sel(ex_q.rs2, ex_q, mem_q, wb_q);
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_stall_i) begin
            wb_d  = mem_q;
            mem_d = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
            if (!id_valid_i || flush_i || stall_o) begin
                ex_d = c_ex_bubble;
            end else begin
                ex_d = '{valid: 1'b1, rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                         regwrite: id_regwrite_i, memread: id_memread_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= c_ex_bubble;
            mem_q <= c_late_bubble;
            wb_q  <= c_late_bubble;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port id_valid_i, input, 1, instruction present in ID.
REQ-005 SHALL have ports id_rs1_i and id_rs2_i, input, REG_W, source register indices of the ID instruction.
REQ-006 SHALL have port id_rd_i, input, REG_W, destination index of the ID instruction.
REQ-007 SHALL have ports id_regwrite_i and id_memread_i, input, 1, ID instruction writes the register file / is a load.
REQ-008 SHALL have port flush_i, input, 1, squash the ID instruction (branch taken).
REQ-009 SHALL have port mem_stall_i, input, 1, L1 data cache miss; freezes the pipeline.
REQ-010 SHALL have ports fwd_a_o and fwd_b_o, output, 2, select codes for the EX-stage operand A/B 4:1 forwarding muxes.
REQ-011 SHALL have port stall_o, output, 1, load-use hazard; holds PC and IF/ID and inserts a bubble.

Function
REQ-012 SHALL keep three stage records (EX, MEM, WB), each holding {valid, rs1, rs2, rd, regwrite, memread}; rs fields are meaningful in EX only.
REQ-013 SHALL, on each clock edge with mem_stall_i=0, shift WB<=MEM, MEM<=EX, and EX<=ID record.
REQ-014 SHALL load EX with a bubble (valid=0, regwrite=0, memread=0) when id_valid_i=0, flush_i=1, or stall_o=1.
REQ-015 SHALL hold all three records unchanged while mem_stall_i=1, regardless of flush_i or stall_o.
REQ-016 SHALL encode select codes as: 2'b00 ID/EX register-file data; 2'b01 MEM/WB write-back data; 2'b10 EX/MEM ALU result; 2'b11 never driven.
REQ-017 SHALL drive fwd_a_o=2'b10 when MEM.valid, MEM.regwrite, MEM.rd!=0 and MEM.rd==EX.rs1.
REQ-018 SHALL otherwise drive fwd_a_o=2'b01 when WB.valid, WB.regwrite, WB.rd!=0 and WB.rd==EX.rs1; else 2'b00.
REQ-019 SHALL derive fwd_b_o identically against EX.rs2.
REQ-020 SHALL drive fwd_a_o/fwd_b_o=2'b00 whenever EX.valid=0.
REQ-021 SHALL derive fwd_*_o from stage records only, with no combinational path from ID inputs (zero added latency: valid in the same cycle EX is occupied).
REQ-022 SHALL assert stall_o combinationally when id_valid_i, EX.valid, EX.memread, EX.rd!=0 and EX.rd equals id_rs1_i or id_rs2_i.
REQ-023 SHALL force stall_o=0 when flush_i=1 or mem_stall_i=1.
REQ-024 SHALL never forward or stall on register index 0, even if a record has regwrite=1 and rd=0.
REQ-025 SHALL, when MEM and WB both match, give MEM (2'b10) priority.

Reset
REQ-026 SHALL, while rst_i=0, clear all record valid/regwrite/memread bits and drive fwd_a_o=fwd_b_o=2'b00, stall_o=0, asynchronously.
REQ-027 SHALL discard in-flight records on reset mid-operation; the first edge after release loads EX from the ID inputs per REQ-013/014.

Verification
REQ-028 SHALL verify: add x5 in EX, next ID uses rs1=x5 -> next cycle fwd_a_o=2'b10, fwd_b_o=2'b00; cycle after, with a new EX reading x5: fwd_a_o=2'b01.
REQ-029 SHALL verify: lw x7 in EX, ID rs2=x7 -> stall_o=1 for one cycle, EX bubble (fwd 00), then fwd_b_o=2'b01 when the consumer reaches EX.
REQ-030 SHALL verify: MEM and WB both write x3, EX rs1=rs2=x3 -> fwd_a_o=fwd_b_o=2'b10.
REQ-031 SHALL verify: writes to x0 in MEM and WB, EX rs1=x0 -> fwd_a_o=2'b00; lw x0 in EX with ID rs1=x0 -> stall_o=0.
REQ-032 SHALL verify: mem_stall_i=1 for 5 cycles with an EX/MEM match -> fwd_a_o stays 2'b10, records frozen, stall_o=0; flush_i during the stall has no effect.
REQ-033 SHALL verify: rst_i low mid-stream between clock edges -> outputs 00/0 immediately; after release no stale forwarding occurs.
